// File: rtl/snn_neuron_sequencer_pkg.sv
// Shared types and default parameters for the time-multiplexed
// integrate-and-fire neuron sequencer.
package snn_pkg;

    // RUN accepts weights; EMIT holds one spike event until it is taken.
    typedef enum logic {
        RUN  = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int DEF_N_NEURONS = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_THRESHOLD = 128;

endpackage

// File: rtl/snn_neuron_sequencer_if.sv
// Weight input stream, spike-event output stream and timestep status
// of the neuron sequencer, bundled as one interface.
interface snn_neuron_sequencer_if
    import snn_pkg::*;
#(
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int WIDTH     = DEF_WIDTH
);
    localparam int AW = $clog2(N_NEURONS);
    localparam int CW = $clog2(N_NEURONS + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_weight;
    logic             ev_valid;
    logic             ev_ready;
    logic [AW-1:0]    ev_addr;
    logic             step_done;
    logic [CW-1:0]    step_spikes;

    // Weight source and spike consumer side.
    modport master (
        output in_valid, in_weight, ev_ready,
        input  in_ready, ev_valid, ev_addr, step_done, step_spikes
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_weight, ev_ready,
        output in_ready, ev_valid, ev_addr, step_done, step_spikes
    );

endinterface

// File: rtl/snn_neuron_sequencer_if_datapath.sv
// Shared integrate/compare/subtract datapath. Purely combinational:
// adds the weight to the membrane, decides whether the neuron fires and
// produces the next membrane value (reset-by-subtraction, saturated).
module if_datapath #(
    parameter int WIDTH     = 8,
    parameter int THRESHOLD = 128
) (
    input  logic [WIDTH-1:0] mem,
    input  logic [WIDTH-1:0] weight,
    output logic             fire,
    output logic [WIDTH-1:0] mem_next
);
    localparam logic [WIDTH:0] TH = (WIDTH + 1)'(THRESHOLD);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Sum in WIDTH+1 bits; a firing residue can still exceed WIDTH bits.
    always_comb begin
        sum  = {1'b0, mem} + {1'b0, weight};
        diff = sum - TH;
        fire = (sum >= TH);
        if (fire) begin
            mem_next = diff[WIDTH] ? {WIDTH{1'b1}} : diff[WIDTH-1:0];
        end else begin
            mem_next = sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/snn_neuron_sequencer.sv
// Time-multiplexed integrate-and-fire controller: one weight per neuron
// per timestep, round-robin, spikes emitted as AER events.
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | in_ready=1, accept a weight for neuron idx each cycle
// EMIT  | in_ready=0, ev_valid=1, hold ev_addr until ev_ready
module snn_neuron_sequencer
    import snn_pkg::*;
#(
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int THRESHOLD = DEF_THRESHOLD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    snn_neuron_sequencer_if.slave bus
);
    localparam int AW = $clog2(N_NEURONS);
    localparam int CW = $clog2(N_NEURONS + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);

    state_t           state;
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] mem [N_NEURONS];
    logic [CW-1:0]    run_cnt;
    logic             in_ready_q;
    logic             ev_valid_q;
    logic [AW-1:0]    ev_addr_q;
    logic             step_done_q;
    logic [CW-1:0]    step_spikes_q;

    logic             fire;
    logic [WIDTH-1:0] mem_next;
    logic             last;

    if_datapath #(
        .WIDTH     (WIDTH),
        .THRESHOLD (THRESHOLD)
    ) u_datapath (
        .mem      (mem[idx]),
        .weight   (bus.in_weight),
        .fire     (fire),
        .mem_next (mem_next)
    );

    // Last neuron of the timestep is being visited.
    always_comb begin
        last = (idx == LAST_IDX);
    end

    // FSM, membrane array, index, counters and registered handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            idx           <= '0;
            run_cnt       <= '0;
            in_ready_q    <= 1'b1;
            ev_valid_q    <= 1'b0;
            ev_addr_q     <= '0;
            step_done_q   <= 1'b0;
            step_spikes_q <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            // step_spikes survives a clear; everything else restarts.
            state       <= RUN;
            idx         <= '0;
            run_cnt     <= '0;
            in_ready_q  <= 1'b1;
            ev_valid_q  <= 1'b0;
            step_done_q <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            step_done_q <= 1'b0;
            case (state)
                RUN: begin
                    if (bus.in_valid) begin
                        mem[idx] <= mem_next;
                        idx      <= last ? '0 : idx + 1'b1;
                        if (fire) begin
                            ev_addr_q  <= idx;
                            ev_valid_q <= 1'b1;
                            in_ready_q <= 1'b0;
                            state      <= EMIT;
                        end
                        if (last) begin
                            step_spikes_q <= run_cnt + CW'(fire);
                            run_cnt       <= '0;
                            step_done_q   <= 1'b1;
                        end else if (fire) begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (bus.ev_ready) begin
                        ev_valid_q <= 1'b0;
                        in_ready_q <= 1'b1;
                        state      <= RUN;
                    end
                end
                default: begin
                    ev_valid_q <= 1'b0;
                    in_ready_q <= 1'b1;
                    state      <= RUN;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.ev_valid    = ev_valid_q;
    assign bus.ev_addr     = ev_addr_q;
    assign bus.step_done   = step_done_q;
    assign bus.step_spikes = step_spikes_q;

endmodule

// File: tb/tb_snn_neuron_sequencer.sv
// Testbench for snn_neuron_sequencer: behavioural neuron model feeds a
// scoreboard of expected spike addresses and per-timestep spike counts.
module tb_snn_neuron_sequencer;
    import snn_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TH = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;

    always #5 clk = ~clk;

    snn_neuron_sequencer_if #(.N_NEURONS(N), .WIDTH(W)) bus ();

    snn_neuron_sequencer #(
        .N_NEURONS (N),
        .WIDTH     (W),
        .THRESHOLD (TH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    int m_mem [N];
    int m_idx  = 0;
    int m_cnt  = 0;
    int m_last = 0;
    int ev_q [$];
    int sp_q [$];

    logic       obs_v = 1'b0;
    logic [1:0] obs_a = '0;
    logic       hold = 1'b0;
    logic [1:0] hold_addr = '0;

    // Capture event outputs mid-cycle; check holds that were not taken.
    always @(negedge clk) begin
        obs_v = bus.ev_valid;
        obs_a = bus.ev_addr;
        if (hold) begin
            total_cnt++;
            if (bus.ev_valid !== 1'b1 || bus.ev_addr !== hold_addr)
                $display("FAIL ev_hold: got valid=%0b addr=%0d want valid=1 addr=%0d",
                         bus.ev_valid, bus.ev_addr, hold_addr);
            else pass_cnt++;
            hold = 1'b0;
        end
        if (rst_n && bus.step_done === 1'b1) begin
            total_cnt++;
            if (sp_q.size() == 0) begin
                $display("FAIL step_unexpected: got step_done=1 want 0");
            end else begin
                int e;
                e = sp_q.pop_front();
                if (int'(bus.step_spikes) != e)
                    $display("FAIL step_spikes: got %0d want %0d", bus.step_spikes, e);
                else pass_cnt++;
            end
        end
    end

    // At the clock edge: a valid event with ev_ready is consumed.
    always @(posedge clk) begin
        if (rst_n && !clr && obs_v === 1'b1) begin
            if (bus.ev_ready === 1'b1) begin
                total_cnt++;
                if (ev_q.size() == 0) begin
                    $display("FAIL ev_unexpected: got addr=%0d want no event", obs_a);
                end else begin
                    int e;
                    e = ev_q.pop_front();
                    if (int'(obs_a) != e)
                        $display("FAIL ev_addr: got %0d want %0d", obs_a, e);
                    else pass_cnt++;
                end
            end else begin
                hold      = 1'b1;
                hold_addr = obs_a;
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_mem[i] = 0;
        m_idx = 0;
        m_cnt = 0;
        ev_q.delete();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        model_clear();
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Send one weight (called and returning at a negedge) and check the
    // cycle-after-accept state against the model.
    task automatic send_word(input int w);
        int  n, k, s;
        bit  f, lst;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) begin
            total_cnt++;
            $display("FAIL in_ready_timeout: got in_ready=%0b want 1", bus.in_ready);
            return;
        end
        bus.in_valid  = 1'b1;
        bus.in_weight = w[W-1:0];
        k = m_idx;
        s = m_mem[k] + w;
        f = (s >= TH);
        if (f) begin
            m_mem[k] = (s - TH > 255) ? 255 : s - TH;
            ev_q.push_back(k);
            m_cnt++;
        end else begin
            m_mem[k] = s;
        end
        lst = (k == N - 1);
        if (lst) begin
            sp_q.push_back(m_cnt);
            m_last = m_cnt;
            m_cnt  = 0;
        end
        m_idx = (k + 1) % N;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.ev_valid !== f || bus.in_ready !== !f || bus.step_done !== lst)
            $display("FAIL accept_flags n%0d: got ev_valid=%0b in_ready=%0b step_done=%0b want %0b %0b %0b",
                     k, bus.ev_valid, bus.in_ready, bus.step_done, f, !f, lst);
        else pass_cnt++;
        total_cnt++;
        if (dut.mem[k] !== 8'(m_mem[k]) || int'(dut.idx) != m_idx)
            $display("FAIL mem_idx n%0d: got mem=%0d idx=%0d want mem=%0d idx=%0d",
                     k, dut.mem[k], dut.idx, m_mem[k], m_idx);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.in_ready !== 1'b1 || bus.ev_valid !== 1'b0 || bus.ev_addr !== 2'd0 ||
            bus.step_done !== 1'b0 || bus.step_spikes !== 3'd0)
            $display("FAIL reset_outputs: got rdy=%0b ev=%0b addr=%0d sd=%0b ss=%0d want 1 0 0 0 0",
                     bus.in_ready, bus.ev_valid, bus.ev_addr, bus.step_done, bus.step_spikes);
        else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            total_cnt++;
            if (dut.mem[i] !== 8'd0) $display("FAIL reset_mem%0d: got %0d want 0", i, dut.mem[i]);
            else pass_cnt++;
        end
        model_clear();
    endtask

    task automatic test_two_steps();
        bus.ev_ready = 1'b1;
        for (int st = 0; st < 2; st++) begin
            for (int i = 0; i < N; i++) begin
                send_word(64);
                if (st == 1) begin
                    @(negedge clk);
                    total_cnt++;
                    if (bus.in_ready !== 1'b1 || bus.ev_valid !== 1'b0)
                        $display("FAIL bubble n%0d: got in_ready=%0b ev_valid=%0b want 1 0",
                                 i, bus.in_ready, bus.ev_valid);
                    else pass_cnt++;
                end
            end
        end
        total_cnt++;
        if (bus.step_spikes !== 3'd4) $display("FAIL two_step_spikes: got %0d want 4", bus.step_spikes);
        else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            total_cnt++;
            if (dut.mem[i] !== 8'd0) $display("FAIL two_step_mem%0d: got %0d want 0", i, dut.mem[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        do_clr();
        bus.ev_ready = 1'b0;
        send_word(200);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.ev_valid !== 1'b1 || bus.ev_addr !== 2'd0 || bus.in_ready !== 1'b0 ||
                dut.idx !== 2'd1 || dut.mem[0] !== 8'd72)
                $display("FAIL backpressure c%0d: got ev=%0b addr=%0d rdy=%0b idx=%0d mem0=%0d want 1 0 0 1 72",
                         c, bus.ev_valid, bus.ev_addr, bus.in_ready, dut.idx, dut.mem[0]);
            else pass_cnt++;
        end
        bus.ev_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.in_ready !== 1'b1 || bus.ev_valid !== 1'b0)
            $display("FAIL bp_release: got rdy=%0b ev=%0b want 1 0", bus.in_ready, bus.ev_valid);
        else pass_cnt++;
        for (int i = 1; i < N; i++) send_word(0);
    endtask

    task automatic test_saturation();
        int sat_exp [3] = '{127, 254, 255};
        do_clr();
        bus.ev_ready = 1'b1;
        for (int st = 0; st < 3; st++) begin
            send_word(255);
            total_cnt++;
            if (int'(dut.mem[0]) != sat_exp[st])
                $display("FAIL saturation s%0d: got %0d want %0d", st, dut.mem[0], sat_exp[st]);
            else pass_cnt++;
            for (int i = 1; i < N; i++) send_word(0);
        end
    endtask

    task automatic test_clr_emit();
        do_clr();
        bus.ev_ready = 1'b0;
        send_word(10);
        send_word(200);
        clr           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_weight = 8'd50;
        model_clear();
        @(negedge clk);
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.ev_valid !== 1'b0 || bus.in_ready !== 1'b1 || dut.idx !== 2'd0 ||
            bus.step_done !== 1'b0 || int'(bus.step_spikes) != m_last)
            $display("FAIL clr_emit: got ev=%0b rdy=%0b idx=%0d sd=%0b ss=%0d want 0 1 0 0 %0d",
                     bus.ev_valid, bus.in_ready, dut.idx, bus.step_done, bus.step_spikes, m_last);
        else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            total_cnt++;
            if (dut.mem[i] !== 8'd0) $display("FAIL clr_mem%0d: got %0d want 0", i, dut.mem[i]);
            else pass_cnt++;
        end
        clr           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_weight = 8'd50;
        @(negedge clk);
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        total_cnt++;
        if (dut.idx !== 2'd0 || dut.mem[0] !== 8'd0)
            $display("FAIL clr_blocks_accept: got idx=%0d mem0=%0d want 0 0", dut.idx, dut.mem[0]);
        else pass_cnt++;
        bus.ev_ready = 1'b1;
    endtask

    task automatic test_boundary();
        do_clr();
        bus.ev_ready = 1'b1;
        for (int i = 0; i < N - 1; i++) send_word(0);
        send_word(200);
        total_cnt++;
        if (bus.step_done !== 1'b1 || bus.ev_valid !== 1'b1 || bus.step_spikes !== 3'd1 ||
            bus.ev_addr !== 2'd3)
            $display("FAIL boundary: got sd=%0b ev=%0b ss=%0d addr=%0d want 1 1 1 3",
                     bus.step_done, bus.ev_valid, bus.step_spikes, bus.ev_addr);
        else pass_cnt++;
        send_word(10);
        total_cnt++;
        if (dut.mem[0] !== 8'd10 || dut.idx !== 2'd1)
            $display("FAIL boundary_wrap: got mem0=%0d idx=%0d want 10 1", dut.mem[0], dut.idx);
        else pass_cnt++;
        for (int i = 1; i < N; i++) send_word(0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_weight = '0;
        bus.ev_ready  = 1'b1;
        test_reset();
        test_two_steps();
        test_backpressure();
        test_saturation();
        test_clr_emit();
        test_boundary();
        repeat (3) @(negedge clk);
        total_cnt++;
        if (ev_q.size() != 0 || sp_q.size() != 0)
            $display("FAIL scoreboard_drain: got ev_q=%0d sp_q=%0d want 0 0", ev_q.size(), sp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/snn_neuron_sequencer.md
# snn_neuron_sequencer

Time-multiplexed integrate-and-fire controller. One accumulate/compare/subtract datapath is shared across N_NEURONS virtual neurons, whose membrane potentials live in a register array. The block consumes one input weight per neuron per timestep through a valid/ready stream, visits neurons round-robin, and emits each spike as an address-event (AER) through a valid/ready handshake. It sits between the input-weight source and the spike-event consumer of the tiny SNN core.

## Interface
- N_NEURONS, 4: number of virtual neurons, ≥2
- WIDTH, 8: membrane and weight width in bits
- THRESHOLD, 128: firing threshold, 1..2^WIDTH-1
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear of membranes, index, counters and any pending event
- in_valid  in  1  input weight valid
- in_ready  out  1  block accepts a weight this cycle
- in_weight  in  WIDTH  unsigned weight for neuron at the current index
- ev_valid  out  1  spike event pending
- ev_ready  in  1  consumer accepts event
- ev_addr  out  $clog2(N_NEURONS)  index of the spiking neuron
- step_done  out  1  one-cycle pulse, timestep complete
- step_spikes  out  $clog2(N_NEURONS+1)  spike count of the last completed timestep

## Operation
- States: RUN (in_ready=1, ev_valid=0) and EMIT (in_ready=0, ev_valid=1).
- Accept occurs on in_valid && in_ready. Neuron index idx starts at 0 and increments on every accept, wrapping from N_NEURONS-1 to 0.
- On accept: sum = mem[idx] + in_weight, computed in WIDTH+1 bits.
  - If sum ≥ THRESHOLD: mem[idx] ← min(sum − THRESHOLD, 2^WIDTH−1); ev_addr ← idx; go to EMIT; increment the running spike count.
  - Otherwise: mem[idx] ← sum, which always fits in WIDTH bits; stay in RUN.
- In EMIT: hold ev_valid and ev_addr stable until ev_ready is high, then return to RUN.
- Accepting idx = N_NEURONS-1:
  - step_done pulses the next cycle.
  - step_spikes ← running count, including a spike from this word.
  - The running count resets to 0.
- clr has priority over everything:
  - Next cycle: all mem = 0, idx = 0, running count = 0, state RUN, ev_valid = 0. A pending event is dropped.
  - step_spikes is retained; step_done is not pulsed.
  - An in_valid presented with clr is not accepted.
- Reset values: in_ready=1, ev_valid=0, ev_addr=0, step_done=0, step_spikes=0. All mem=0, idx=0, state RUN.

## Timing
- Accept at cycle t:
  - mem update, ev_valid/ev_addr and step_done are all visible at t+1.
  - in_ready falls at t+1 when a spike occurs.
- Spike-free streaming: one weight per cycle.
- Each spike costs at least one bubble. Accept at t, EMIT at t+1; with ev_ready=1 at t+1, in_ready=1 at t+2.
- ev_valid never drops without a handshake, except on clr or reset.
- ev_ready while in RUN is ignored.
- Reset mid-EMIT drops the event immediately (asynchronous).

## Structure
- Package snn_pkg holds:
  - the state enum (RUN, EMIT)
  - default WIDTH and THRESHOLD constants
- Sub-module if_datapath: purely combinational. Inputs mem, weight, THRESHOLD; outputs fire and the saturated next membrane value.
- The controller holds the FSM, idx, mem array, counters and handshake registers.

## Test plan
- Reset: after rst_n release, outputs are in_ready=1, ev_valid=0, ev_addr=0, step_done=0, step_spikes=0.
- Two timesteps, all four neurons: weight 64 to all neurons (N=4).
  - Step 1: no events; step_done pulse; step_spikes=0.
  - Step 2: events with ev_addr 0,1,2,3 in order, each with a single bubble; step_spikes=4; all mem=0.
- Backpressure: weight 200 to neuron 0 with ev_ready low for 5 cycles.
  - ev_valid=1 and ev_addr=0 held throughout; in_ready=0; idx stays 1.
  - mem[0]=72; handshake on cycle 6; in_ready=1 the next cycle.
- Saturation: weight 255 to neuron 0 for three timesteps, 0 to the others.
  - Spike each step; mem[0] = 127, then 254, then 255 (saturated).
- clr in EMIT: assert clr while ev_valid=1.
  - Next cycle: ev_valid=0, in_ready=1, idx=0, all mem=0, no step_done.
- Boundary: the last neuron's word spikes.
  - step_done and ev_valid assert in the same cycle.
  - step_spikes includes that spike.
  - The next accepted word goes to neuron 0.
